// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit and memory.
// The fetch unit holds the request until memory returns i_mem_ready.
interface fetch_unit_if;
  logic        i_mem_read;
  logic [15:0] i_address;
  logic [15:0] i_data;
  logic        i_mem_ready;

  modport master (
    output i_mem_read,
    output i_address,
    input  i_data,
    input  i_mem_ready
  );

  modport slave (
    input  i_mem_read,
    input  i_address,
    output i_data,
    output i_mem_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one outstanding memory read at a time, fills the
// instruction register through a one-entry skid buffer, and handles redirect/halt.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  fetch_unit_if.master        mem,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [15:0]         redirect_pc,
  input  logic                halt,
  output logic [15:0]         ir,
  output logic                ir_valid,
  output logic [3:0]          opcode,
  output logic [5:0]          func_code,
  output logic [15:0]         ir_pc,
  output logic [15:0]         num_fetched
);

  typedef enum logic [1:0] {FETCH, FULL, HALTED} state_t;

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] req_addr;
  logic        squash, squash_n;
  logic [15:0] ir_n, ir_pc_n;
  logic        ir_valid_n;
  logic [15:0] skid, skid_n, skid_pc, skid_pc_n;
  logic        skid_valid, skid_valid_n;
  logic [15:0] num_fetched_n;
  logic        resp;

  // A squashed request must stay visible on the bus until memory completes it.
  assign mem.i_mem_read = (state == FETCH) || squash;
  assign mem.i_address  = req_addr;
  assign resp           = mem.i_mem_read && mem.i_mem_ready;

  assign opcode    = ir[15:12];
  assign func_code = ir[5:0];

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    squash_n      = squash;
    ir_n          = ir;
    ir_pc_n       = ir_pc;
    ir_valid_n    = ir_valid;
    skid_n        = skid;
    skid_pc_n     = skid_pc;
    skid_valid_n  = skid_valid;
    num_fetched_n = num_fetched;

    if (state == HALTED) begin
      if (resp) begin
        squash_n = 1'b0;
      end
    end else if (redirect_valid) begin
      ir_valid_n   = 1'b0;
      skid_valid_n = 1'b0;
      pc_n         = redirect_pc;
      state_n      = FETCH;
      squash_n     = mem.i_mem_read && !mem.i_mem_ready;
    end else if (halt && ir_valid) begin
      state_n  = HALTED;
      squash_n = mem.i_mem_read && !mem.i_mem_ready;
    end else if (state == FULL) begin
      if (!stall) begin
        ir_n          = skid;
        ir_pc_n       = skid_pc;
        skid_valid_n  = 1'b0;
        num_fetched_n = num_fetched + 16'd1;
        state_n       = FETCH;
      end
    end else if (resp && squash) begin
      squash_n = 1'b0;
      if (ir_valid && !stall) begin
        ir_valid_n = 1'b0;
      end
    end else if (resp) begin
      pc_n = req_addr + 16'd1;
      if (!ir_valid || !stall) begin
        ir_n          = mem.i_data;
        ir_pc_n       = req_addr;
        ir_valid_n    = 1'b1;
        num_fetched_n = num_fetched + 16'd1;
      end else begin
        // Consumer is stalled on a live IR: park the word and stop requesting.
        skid_n       = mem.i_data;
        skid_pc_n    = req_addr;
        skid_valid_n = 1'b1;
        state_n      = FULL;
      end
    end else if (ir_valid && !stall) begin
      ir_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      req_addr    <= RESET_PC;
      squash      <= 1'b0;
      ir          <= 16'h0000;
      ir_pc       <= 16'h0000;
      ir_valid    <= 1'b0;
      skid        <= 16'h0000;
      skid_pc     <= 16'h0000;
      skid_valid  <= 1'b0;
      num_fetched <= 16'h0000;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      squash      <= squash_n;
      ir          <= ir_n;
      ir_pc       <= ir_pc_n;
      ir_valid    <= ir_valid_n;
      skid        <= skid_n;
      skid_pc     <= skid_pc_n;
      skid_valid  <= skid_valid_n;
      num_fetched <= num_fetched_n;
      // The request address is frozen while a read is in flight.
      if (!mem.i_mem_read || mem.i_mem_ready) begin
        req_addr <= pc_n;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, skid/FULL, redirect squash,
// coincident redirect, address wrap, halt and reset recovery.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt;
  logic [15:0] ir;
  logic        ir_valid;
  logic [3:0]  opcode;
  logic [5:0]  func_code;
  logic [15:0] ir_pc;
  logic [15:0] num_fetched;

  int checks = 0;
  int errors = 0;

  fetch_unit_if mem ();

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem            (mem),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .ir             (ir),
    .ir_valid       (ir_valid),
    .opcode         (opcode),
    .func_code      (func_code),
    .ir_pc          (ir_pc),
    .num_fetched    (num_fetched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the rising edge take them, sample 1 ns later.
  task automatic applyStimulus(input logic rdy, input logic [15:0] data,
                               input logic stl, input logic redir,
                               input logic [15:0] rpc, input logic hlt);
    mem.i_mem_ready = rdy;
    mem.i_data      = data;
    stall           = stl;
    redirect_valid  = redir;
    redirect_pc     = rpc;
    halt            = hlt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    $display("[TB] fetch_unit directed test start");
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("rst_ir", ir, 16'h0000);
    checkOutput("rst_ir_valid", ir_valid, 1'b0);
    checkOutput("rst_num", num_fetched, 16'h0000);
    checkOutput("rst_ir_pc", ir_pc, 16'h0000);
    reset = 1'b0;
    #1;
    checkOutput("first_read", mem.i_mem_read, 1'b1);
    checkOutput("first_addr", mem.i_address, 16'h0000);

    // Back-to-back fetch with memory ready every cycle.
    applyStimulus(1'b1, 16'h1000, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("seq0_ir", ir, 16'h1000);
    checkOutput("seq0_valid", ir_valid, 1'b1);
    checkOutput("seq0_addr", mem.i_address, 16'h0001);
    applyStimulus(1'b1, 16'h2011, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("seq1_ir_pc", ir_pc, 16'h0001);
    checkOutput("seq1_addr", mem.i_address, 16'h0002);
    applyStimulus(1'b1, 16'h3022, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("seq2_num", num_fetched, 16'h0003);
    checkOutput("seq2_opcode", opcode, 4'h3);
    checkOutput("seq2_func", func_code, 6'h22);
    checkOutput("seq2_addr", mem.i_address, 16'h0003);

    // Stall with a live IR: the next word lands in the skid buffer.
    applyStimulus(1'b1, 16'hA001, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("pre_stall_ir", ir, 16'hA001);
    applyStimulus(1'b1, 16'hB002, 1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'hC003, 1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'hC003, 1'b1, 1'b0, 16'h0000, 1'b0);
    applyStimulus(1'b1, 16'hC003, 1'b1, 1'b0, 16'h0000, 1'b0);
    checkOutput("full_read", mem.i_mem_read, 1'b0);
    checkOutput("full_ir", ir, 16'hA001);
    checkOutput("full_ir_pc", ir_pc, 16'h0003);
    checkOutput("full_num", num_fetched, 16'h0004);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("skid_ir", ir, 16'hB002);
    checkOutput("skid_ir_pc", ir_pc, 16'h0004);
    checkOutput("skid_num", num_fetched, 16'h0005);
    checkOutput("skid_read", mem.i_mem_read, 1'b1);
    checkOutput("skid_addr", mem.i_address, 16'h0005);

    // IR consumed with no new word.
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("drain_valid", ir_valid, 1'b0);

    // Redirect while the request to 5 is pending: squash it.
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 1'b0);
    checkOutput("sq_hold_addr", mem.i_address, 16'h0005);
    checkOutput("sq_read", mem.i_mem_read, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("sq_hold_addr2", mem.i_address, 16'h0005);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("sq_drop_valid", ir_valid, 1'b0);
    checkOutput("sq_drop_num", num_fetched, 16'h0005);
    checkOutput("sq_new_addr", mem.i_address, 16'h0040);
    applyStimulus(1'b1, 16'h4140, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("sq_after_ir", ir, 16'h4140);
    checkOutput("sq_after_ir_pc", ir_pc, 16'h0040);
    checkOutput("sq_after_num", num_fetched, 16'h0006);

    // Redirect coincident with ready: word dropped, next request at target.
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b1, 16'h0100, 1'b0);
    checkOutput("co_valid", ir_valid, 1'b0);
    checkOutput("co_addr", mem.i_address, 16'h0100);
    checkOutput("co_num", num_fetched, 16'h0006);

    // Fetch at 16'hFFFF wraps to 0.
    applyStimulus(1'b1, 16'h1234, 1'b0, 1'b1, 16'hFFFF, 1'b0);
    checkOutput("wrap_pre_addr", mem.i_address, 16'hFFFF);
    applyStimulus(1'b1, 16'h5AFF, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("wrap_ir_pc", ir_pc, 16'hFFFF);
    checkOutput("wrap_addr", mem.i_address, 16'h0000);
    checkOutput("wrap_num", num_fetched, 16'h0007);

    // Halt with a request outstanding: it completes, is dropped, then no reads.
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("halt_pend_read", mem.i_mem_read, 1'b1);
    checkOutput("halt_pend_addr", mem.i_address, 16'h0000);
    applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0000, 1'b1);
    checkOutput("halt_read", mem.i_mem_read, 1'b0);
    checkOutput("halt_ir", ir, 16'h5AFF);
    checkOutput("halt_ir_pc", ir_pc, 16'hFFFF);
    checkOutput("halt_num", num_fetched, 16'h0007);
    applyStimulus(1'b1, 16'h8888, 1'b0, 1'b1, 16'h0200, 1'b0);
    checkOutput("halted_read", mem.i_mem_read, 1'b0);
    checkOutput("halted_ir", ir, 16'h5AFF);
    checkOutput("halted_valid", ir_valid, 1'b1);

    // Only reset leaves HALTED.
    reset = 1'b1;
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("rerst_ir", ir, 16'h0000);
    checkOutput("rerst_valid", ir_valid, 1'b0);
    checkOutput("rerst_num", num_fetched, 16'h0000);
    checkOutput("rerst_read", mem.i_mem_read, 1'b1);
    checkOutput("rerst_addr", mem.i_address, 16'h0000);
    applyStimulus(1'b1, 16'h9ABC, 1'b0, 1'b0, 16'h0000, 1'b0);
    checkOutput("rerst_ir2", ir, 16'h9ABC);
    checkOutput("rerst_num2", num_fetched, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL set the first fetch address after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-004 Port i_mem_read  output  1  SHALL be the instruction-memory read request.
REQ-005 Port i_address  output  16  SHALL be the address of the outstanding request.
REQ-006 Port i_data  input  16  SHALL be the returned instruction word, valid when i_mem_ready=1.
REQ-007 Port i_mem_ready  input  1  SHALL complete the outstanding request.
REQ-008 Port stall  input  1  SHALL be held high by the consumer when it does not take the IR this cycle.
REQ-009 Port redirect_valid  input  1  SHALL request a PC change (branch/jump resolved).
REQ-010 Port redirect_pc  input  16  SHALL be the new fetch address.
REQ-011 Port halt  input  1  SHALL be the control unit's halt indication (HLT in IR).
REQ-012 Port ir  output  16  SHALL be the current instruction register.
REQ-013 Port ir_valid  output  1  SHALL indicate ir holds a live instruction.
REQ-014 Port opcode  output  4  SHALL equal ir[15:12].
REQ-015 Port func_code  output  6  SHALL equal ir[5:0].
REQ-016 Port ir_pc  output  16  SHALL be the fetch address of ir.
REQ-017 Port num_fetched  output  16  SHALL count instructions accepted into ir.

Function
REQ-018 States: FETCH, FULL, HALTED, held in a state register.
REQ-019 i_mem_read SHALL be 1 only in FETCH, or while a squashed request is still outstanding.
REQ-020 Once i_mem_read=1, i_address SHALL stay stable (req_addr register) until the cycle i_mem_ready=1.
REQ-021 FETCH, ready, no squash, no redirect: if ir_valid=0 or stall=0, ir<=i_data, ir_pc<=req_addr, ir_valid<=1. Otherwise the word SHALL go to a one-entry skid buffer.
REQ-022 On each accepted response, pc SHALL become req_addr+1 (16-bit wrap, 16'hFFFF->16'h0000), and the next request SHALL issue the following cycle.
REQ-023 IR consumed (ir_valid=1, stall=0) with no new word: ir_valid<=0, or the skid word SHALL move into ir.
REQ-024 With skid and ir both full, state SHALL go to FULL. FULL->FETCH SHALL occur the cycle stall=0, with the skid word moving to ir.
REQ-025 redirect_valid=1 SHALL take priority over all but reset: ir_valid<=0, skid cleared, pc<=redirect_pc.
REQ-026 Redirect with an outstanding request not completing that cycle: squash<=1. The next response SHALL be discarded, then fetch SHALL issue at redirect_pc.
REQ-027 Redirect coincident with i_mem_ready=1: that word SHALL be discarded, and the next request SHALL use redirect_pc.
REQ-028 halt=1 with ir_valid=1: no new request SHALL issue; any outstanding request SHALL complete and be discarded; ir and ir_pc SHALL be held; state SHALL go to HALTED.
REQ-029 HALTED SHALL be exited only by reset.
REQ-030 num_fetched SHALL increment by 1 per word written into ir from memory or skid, and wrap at 16'hFFFF.
REQ-031 Discarded words SHALL NOT increment num_fetched.
REQ-032 Outputs ir, opcode, func_code and ir_pc SHALL be registered or directly derived from registered ir; no combinational path from i_data to ir.

Reset
REQ-033 reset=1 SHALL force state=FETCH, pc=req_addr=RESET_PC, ir=16'h0000, ir_pc=0, ir_valid=0, skid empty, squash=0, num_fetched=0.
REQ-034 The first request (i_mem_read=1, i_address=RESET_PC) SHALL appear in the first cycle after reset deasserts.
REQ-035 Reset asserted mid-request SHALL abandon the request, and any late i_mem_ready SHALL be ignored unless a new request is outstanding.

Verification
REQ-036 Reset, memory ready each cycle, stall=0 -> i_address 0,1,2,...; ir_valid=1 from 2nd cycle; num_fetched=3 after 3 responses.
REQ-037 stall=1 held 4 cycles with ir=16'hA001, ready=1 -> next word in skid, state FULL, i_mem_read=0. On stall=0, ir gets the skid word and ir_pc increments by 1.
REQ-038 Request to 16'h0005 pending, redirect_pc=16'h0040 -> i_address stays 5 until ready; that word is discarded; next i_address=16'h0040; num_fetched unchanged by the discard.
REQ-039 redirect coincident with i_mem_ready -> word dropped, ir_valid=0 next cycle, next request at redirect_pc.
REQ-040 halt=1 while a request is outstanding -> response discarded, i_mem_read=0 thereafter, ir and ir_pc hold, HALTED until reset.
REQ-041 pc=16'hFFFF fetch accepted -> next i_address=16'h0000.
